alu_exec_unit: RTL

//  Parametrised EX-stage unit: decodes alu_op/funct3/funct7 into an ALU operation and executes it.

---
 rtl/alu_exec_unit_pkg.sv | 36 +++
 rtl/alu_exec_unit_muldiv_iter.sv | 62 ++++++
 rtl/alu_exec_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: ALU op codes, FSM states and base-op decode shared by the EX unit.
package alu_exec_unit_pkg;
    localparam logic [4:0] ALUADD    = 5'd0;
    localparam logic [4:0] ALUSUB    = 5'd1;
    localparam logic [4:0] ALUAND    = 5'd2;
    localparam logic [4:0] ALUOR     = 5'd3;
    localparam logic [4:0] ALUXOR    = 5'd4;
    localparam logic [4:0] ALUSLT    = 5'd5;
    localparam logic [4:0] ALUSLTU   = 5'd6;
    localparam logic [4:0] ALUSLL    = 5'd7;
    localparam logic [4:0] ALUSRL    = 5'd8;
    localparam logic [4:0] ALUSRA    = 5'd9;
    localparam logic [4:0] ALUMUL    = 5'd10;
    localparam logic [4:0] ALUMULH   = 5'd11;
    localparam logic [4:0] ALUMULHSU = 5'd12;
    localparam logic [4:0] ALUMULHU  = 5'd13;
    localparam logic [4:0] ALUDIV    = 5'd14;
    localparam logic [4:0] ALUDIVU   = 5'd15;
    localparam logic [4:0] ALUREM    = 5'd16;
    localparam logic [4:0] ALUREMU   = 5'd17;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic logic [4:0] base_op(input logic [2:0] f3, input logic sub, input logic sra);
        case (f3)
            3'd0:    return sub ? ALUSUB : ALUADD;
            3'd1:    return ALUSLL;
            3'd2:    return ALUSLT;
            3'd3:    return ALUSLTU;
            3'd4:    return ALUXOR;
            3'd5:    return sra ? ALUSRA : ALUSRL;
            3'd6:    return ALUOR;
            default: return ALUAND;
        endcase
    endfunction
endpackage

// File: rtl/alu_exec_unit_muldiv_iter.sv
// muldiv_iter: iterative shift-add multiplier / restoring divider on operand magnitudes.
module muldiv_iter #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            run,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    logic [2*XLEN-1:0] p, cur, nxt, prod;
    logic [2*XLEN:0]   sh;
    logic [XLEN:0]     sum, diff;
    logic [XLEN-1:0]   m, mcur, a_mag, b_mag, q, r;
    logic [CW-1:0]     cnt;
    logic [2:0]        fop;
    logic              a_neg, b_neg, neg_q, neg_r, dv;

    assign a_neg = a[XLEN-1] && (op[2] ? !op[0] : op[1:0] != 2'b11);
    assign b_neg = b[XLEN-1] && (op[2] ? !op[0] : !op[1]);
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    // First iteration happens on the start edge so results land XLEN+1 cycles after accept
    assign cur   = start ? {{XLEN{1'b0}}, a_mag} : p;
    assign mcur  = start ? b_mag : m;
    assign dv    = start ? op[2] : fop[2];
    assign sum   = {1'b0, cur[2*XLEN-1:XLEN]} + (cur[0] ? {1'b0, mcur} : '0);
    assign sh    = {cur, 1'b0};
    assign diff  = sh[2*XLEN:XLEN] - {1'b0, mcur};
    assign nxt   = !dv ? {sum, cur[XLEN-1:1]} :
                   diff[XLEN] ? sh[2*XLEN-1:0] : {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1};
    assign done  = run && cnt == CW'(XLEN-1);
    assign prod  = neg_q ? -p : p;
    assign q     = p[XLEN-1:0];
    assign r     = p[2*XLEN-1:XLEN];
    assign result = !fop[2] ? (fop[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                    fop[1] ? (neg_r ? -r : r) : (neg_q ? -q : q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p     <= '0;
            m     <= '0;
            cnt   <= '0;
            fop   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            p     <= nxt;
            m     <= b_mag;
            cnt   <= CW'(1);
            fop   <= op;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (run) begin
            p   <= nxt;
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I/M EX-stage unit with 1-cycle ALU ops and iterative MUL/DIV.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            is_imm,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);
    state_t          state;
    logic [4:0]      op;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res, md_res;
    logic            accept, is_m, ill, b_zero, ovf, md_start, md_done, md_run;

    assign in_ready = state == IDLE;
    assign accept   = in_valid && in_ready && !flush;
    assign is_m     = alu_op == 2'b10 && funct7_0 && !is_imm;
    assign ill      = alu_op == 2'b11 || (is_m && !ENABLE_M);
    assign op       = alu_op == 2'b01 ? ALUSUB : alu_op != 2'b10 ? ALUADD :
                      is_m ? ALUMUL + {2'b00, funct3} : base_op(funct3, funct7_5 && !is_imm, funct7_5);
    assign shamt    = op_b[SW-1:0];
    assign b_zero   = op_b == '0;
    assign ovf      = !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
    // Divide-by-zero and signed overflow are resolved by the 1-cycle path
    assign md_start = accept && is_m && !ill && !(funct3[2] && (b_zero || ovf));
    assign md_run   = state == MUL || state == DIV;

    always_comb begin
        alu_res = '0;
        case (op)
            ALUADD:          alu_res = op_a + op_b;
            ALUSUB:          alu_res = op_a - op_b;
            ALUAND:          alu_res = op_a & op_b;
            ALUOR:           alu_res = op_a | op_b;
            ALUXOR:          alu_res = op_a ^ op_b;
            ALUSLT:          alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALUSLTU:         alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALUSLL:          alu_res = op_a << shamt;
            ALUSRL:          alu_res = op_a >> shamt;
            ALUSRA:          alu_res = $signed(op_a) >>> shamt;
            ALUDIV, ALUDIVU: alu_res = b_zero ? '1 : op_a;
            ALUREM, ALUREMU: alu_res = b_zero ? op_a : '0;
            default:         alu_res = '0;
        endcase
        if (ill) alu_res = '0;
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .run    (md_run),
        .op     (funct3),
        .a      (op_a),
        .b      (op_b),
        .done   (md_done),
        .result (md_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (md_start) state <= funct3[2] ? DIV : MUL;
                    else if (accept) begin
                        out_valid <= 1'b1;
                        result    <= alu_res;
                        zero      <= alu_res == '0;
                        illegal   <= ill;
                    end
                end
                MUL, DIV: if (md_done) state <= DONE;
                default: begin
                    out_valid <= 1'b1;
                    result    <= md_res;
                    zero      <= md_res == '0;
                    illegal   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
